// File: rtl/rob_dual_commit_if.sv
// Reorder-buffer bus: issue, writeback, operand lookup,
// commit, redirect and predictor-update signals.
interface rob_dual_commit_if #(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int XLEN     = 32,
    parameter int WB_PORTS = 2
);
    logic                      issue_valid;
    logic [2:0]                issue_type;
    logic [4:0]                issue_rd;
    logic                      issue_done;
    logic [XLEN-1:0]           issue_value;
    logic [XLEN-1:0]           issue_pc;
    logic [XLEN-1:0]           issue_target;
    logic                      issue_pred_taken;
    logic                      issue_ready;
    logic [IDX_W-1:0]          issue_idx;
    logic [WB_PORTS-1:0]       wb_valid;
    logic [WB_PORTS*IDX_W-1:0] wb_idx;
    logic [WB_PORTS*XLEN-1:0]  wb_value;
    logic [2*IDX_W-1:0]        q_idx;
    logic [1:0]                q_ready;
    logic [2*XLEN-1:0]         q_value;
    logic [1:0]                cm_valid;
    logic [9:0]                cm_rd;
    logic [2*IDX_W-1:0]        cm_idx;
    logic [2*XLEN-1:0]         cm_value;
    logic [IDX_W-1:0]          head_idx;
    logic                      head_is_mem;
    logic                      flush;
    logic [XLEN-1:0]           flush_pc;
    logic                      bp_valid;
    logic                      bp_taken;
    logic [XLEN-1:0]           bp_pc;
    logic                      halted;

    modport master (
        output issue_valid, issue_type, issue_rd, issue_done,
        output issue_value, issue_pc, issue_target, issue_pred_taken,
        output wb_valid, wb_idx, wb_value, q_idx,
        input  issue_ready, issue_idx, q_ready, q_value,
        input  cm_valid, cm_rd, cm_idx, cm_value,
        input  head_idx, head_is_mem, flush, flush_pc,
        input  bp_valid, bp_taken, bp_pc, halted
    );

    modport slave (
        input  issue_valid, issue_type, issue_rd, issue_done,
        input  issue_value, issue_pc, issue_target, issue_pred_taken,
        input  wb_valid, wb_idx, wb_value, q_idx,
        output issue_ready, issue_idx, q_ready, q_value,
        output cm_valid, cm_rd, cm_idx, cm_value,
        output head_idx, head_is_mem, flush, flush_pc,
        output bp_valid, bp_taken, bp_pc, halted
    );
endinterface

// File: rtl/rob_dual_commit.sv
// Circular reorder buffer with dual in-order commit and
// branch/JALR resolution at the head.
module rob_dual_commit #(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int XLEN     = 32,
    parameter int WB_PORTS = 2
) (
    input logic clk_in,
    input logic rst_in,
    input logic rdy_in,
    rob_dual_commit_if.slave bus
);
    typedef enum logic [2:0] {
        T_TOREG  = 3'd0,
        T_LOAD   = 3'd1,
        T_STORE  = 3'd2,
        T_BRANCH = 3'd3,
        T_JALR   = 3'd4,
        T_EXIT   = 3'd5
    } rob_type_e;

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0] busy_q, done_q, pred_q;
    rob_type_e        type_q [DEPTH];
    logic [4:0]       rd_q   [DEPTH];
    logic [XLEN-1:0]  val_q  [DEPTH];
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [XLEN-1:0]  tgt_q  [DEPTH];

    logic [IDX_W-1:0] head_q, tail_q, h1;
    logic [IDX_W:0]   cnt_q;
    logic             flush_q, bp_valid_q, bp_taken_q, halted_q;
    logic [XLEN-1:0]  flush_pc_q, bp_pc_q;

    logic                live, ready_c, fire;
    logic                c0, c1, br0, jalr0, exit0, act, flush_now;
    logic [1:0]          ncommit;
    logic [XLEN-1:0]     nfpc;
    logic [WB_PORTS-1:0] wb_hit;
    logic [IDX_W-1:0]    wb_at [WB_PORTS];

    function automatic logic is_ctl(rob_type_e t);
        return t inside {T_BRANCH, T_JALR, T_EXIT};
    endfunction

    function automatic logic to_rf(rob_type_e t);
        return t inside {T_TOREG, T_LOAD, T_JALR};
    endfunction

    // nothing moves during the redirect cycle
    assign live    = rdy_in && !flush_q;
    assign h1      = head_q + 1'b1;
    assign ready_c = live && (cnt_q < FULL);
    assign fire    = bus.issue_valid && ready_c;

    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_at[p]  = bus.wb_idx[p*IDX_W +: IDX_W];
            wb_hit[p] = live && bus.wb_valid[p] && busy_q[wb_at[p]];
        end
    end

    assign c0 = live && !halted_q
             && busy_q[head_q] && done_q[head_q];
    assign c1 = c0 && busy_q[h1] && done_q[h1]
             && !is_ctl(type_q[head_q]) && !is_ctl(type_q[h1]);
    assign ncommit = {1'b0, c0} + {1'b0, c1};

    assign br0   = c0 && (type_q[head_q] == T_BRANCH);
    assign jalr0 = c0 && (type_q[head_q] == T_JALR);
    assign exit0 = c0 && (type_q[head_q] == T_EXIT);
    assign act   = val_q[head_q][0];
    assign flush_now = jalr0 || (br0 && (act != pred_q[head_q]));
    assign nfpc = (jalr0 || act) ? tgt_q[head_q]
                                 : pc_q[head_q] + XLEN'(4);

    always_comb begin
        bus.issue_ready = ready_c;
        bus.issue_idx   = rdy_in ? tail_q : '0;
        bus.head_idx    = rdy_in ? head_q : '0;
        bus.head_is_mem = rdy_in && (cnt_q != '0)
                       && (type_q[head_q] inside {T_LOAD, T_STORE});
        bus.cm_valid = {c1 && to_rf(type_q[h1]),
                        c0 && to_rf(type_q[head_q])};
        bus.cm_rd    = '0;
        bus.cm_idx   = '0;
        bus.cm_value = '0;
        if (c0) begin
            bus.cm_rd[4:0]         = rd_q[head_q];
            bus.cm_idx[IDX_W-1:0]  = head_q;
            bus.cm_value[XLEN-1:0] = val_q[head_q];
        end
        if (c1) begin
            bus.cm_rd[9:5]                = rd_q[h1];
            bus.cm_idx[2*IDX_W-1:IDX_W]   = h1;
            bus.cm_value[2*XLEN-1:XLEN]   = val_q[h1];
        end
    end

    always_comb begin : q_lookup
        logic [IDX_W-1:0] qi;
        bus.q_ready = '0;
        bus.q_value = '0;
        for (int k = 0; k < 2; k++) begin
            qi = bus.q_idx[k*IDX_W +: IDX_W];
            if (rdy_in && busy_q[qi] && done_q[qi]) begin
                bus.q_ready[k] = 1'b1;
                bus.q_value[k*XLEN +: XLEN] = val_q[qi];
            end else begin
                // descending scan so the lowest port wins
                for (int p = WB_PORTS - 1; p >= 0; p--) begin
                    if (wb_hit[p] && wb_at[p] == qi) begin
                        bus.q_ready[k] = 1'b1;
                        bus.q_value[k*XLEN +: XLEN] =
                            (type_q[qi] == T_JALR) ? val_q[qi]
                            : bus.wb_value[p*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= '0;
            done_q     <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
            bp_valid_q <= 1'b0;
            bp_taken_q <= 1'b0;
            bp_pc_q    <= '0;
            halted_q   <= 1'b0;
        end else if (rdy_in) begin
            flush_q    <= flush_now;
            bp_valid_q <= br0;
            if (br0) begin
                bp_pc_q    <= pc_q[head_q];
                bp_taken_q <= act;
            end
            if (flush_now) flush_pc_q <= nfpc;
            if (exit0) halted_q <= 1'b1;
            if (flush_now) begin
                head_q <= '0;
                tail_q <= '0;
                cnt_q  <= '0;
                busy_q <= '0;
            end else begin
                if (fire) begin
                    busy_q[tail_q] <= 1'b1;
                    done_q[tail_q] <= bus.issue_done;
                    tail_q         <= tail_q + 1'b1;
                end
                for (int p = 0; p < WB_PORTS; p++)
                    if (wb_hit[p]) done_q[wb_at[p]] <= 1'b1;
                if (c0) busy_q[head_q] <= 1'b0;
                if (c1) busy_q[h1] <= 1'b0;
                head_q <= head_q + IDX_W'(ncommit);
                cnt_q  <= cnt_q + (IDX_W+1)'(fire)
                        - (IDX_W+1)'(ncommit);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_now) begin
            if (fire) begin
                type_q[tail_q] <= rob_type_e'(bus.issue_type);
                rd_q[tail_q]   <= bus.issue_rd;
                val_q[tail_q]  <= bus.issue_value;
                pc_q[tail_q]   <= bus.issue_pc;
                tgt_q[tail_q]  <= bus.issue_target;
                pred_q[tail_q] <= bus.issue_pred_taken;
            end
            for (int p = WB_PORTS - 1; p >= 0; p--) begin
                if (wb_hit[p]) begin
                    if (type_q[wb_at[p]] == T_JALR)
                        tgt_q[wb_at[p]] <= bus.wb_value[p*XLEN +: XLEN];
                    else
                        val_q[wb_at[p]] <= bus.wb_value[p*XLEN +: XLEN];
                end
            end
        end
    end

    assign bus.flush    = flush_q;
    assign bus.flush_pc = flush_pc_q;
    assign bus.bp_valid = bp_valid_q;
    assign bus.bp_taken = bp_taken_q;
    assign bus.bp_pc    = bp_pc_q;
    assign bus.halted   = halted_q;
endmodule

// File: tb/tb_rob_dual_commit.sv
// Directed bench for rob_dual_commit: fill, dual commit,
// redirects, writeback priority, wrap with stall, exit.
module tb_rob_dual_commit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;

    rob_dual_commit_if b ();

    rob_dual_commit dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (b)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        b.issue_valid = 0; b.issue_type = 0; b.issue_rd = 0;
        b.issue_done = 0; b.issue_value = 0; b.issue_pc = 0;
        b.issue_target = 0; b.issue_pred_taken = 0;
        b.wb_valid = 0; b.wb_idx = 0; b.wb_value = 0; b.q_idx = 0;
    endtask

    task automatic do_reset();
        clear_in();
        rdy = 1'b1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic issue(input logic [2:0] t, input logic [4:0] rd,
                         input logic dn, input logic [31:0] v,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pt, input logic [3:0] exp_idx);
        b.issue_valid = 1; b.issue_type = t; b.issue_rd = rd;
        b.issue_done = dn; b.issue_value = v; b.issue_pc = pc;
        b.issue_target = tgt; b.issue_pred_taken = pt;
        #1;
        chk("issue_idx", 64'(b.issue_idx), 64'(exp_idx));
        step();
        b.issue_valid = 0;
    endtask

    initial begin
        clear_in();
        #2;
        chk("rst_flush", 64'(b.flush), 0);
        chk("rst_halted", 64'(b.halted), 0);
        chk("rst_bp_valid", 64'(b.bp_valid), 0);
        chk("rst_flush_pc", 64'(b.flush_pc), 0);
        chk("rst_head", 64'(b.head_idx), 0);
        chk("rst_cm_valid", 64'(b.cm_valid), 0);
        chk("rst_issue_ready", 64'(b.issue_ready), 1);
        rst_n = 1'b1;
        step();

        // fill all 16 slots
        for (int i = 0; i < 16; i++)
            issue(3'd0, 5'(i + 1), 1'b0, 32'd0, 32'd0, 32'd0,
                  1'b0, 4'(i));
        chk("full_ready", 64'(b.issue_ready), 0);
        chk("full_cm", 64'(b.cm_valid), 0);
        b.issue_valid = 1;
        #1;
        chk("full_idx", 64'(b.issue_idx), 0);
        step();
        b.issue_valid = 0;
        chk("ovf_ready", 64'(b.issue_ready), 0);

        // dual writeback then dual commit
        b.wb_valid = 2'b11;
        b.wb_idx = {4'd1, 4'd0};
        b.wb_value = {32'd6, 32'd5};
        #1;
        chk("wb_pre_cm", 64'(b.cm_valid), 0);
        step();
        clear_in();
        #1;
        chk("dual_cm_valid", 64'(b.cm_valid), 2'b11);
        chk("dual_cm_idx", 64'(b.cm_idx), {4'd1, 4'd0});
        chk("dual_cm_value", b.cm_value, {32'd6, 32'd5});
        chk("dual_cm_rd", 64'(b.cm_rd), {5'd2, 5'd1});
        step();
        chk("dual_ready", 64'(b.issue_ready), 1);
        chk("dual_head", 64'(b.head_idx), 2);

        // mispredicted branch flushes younger entry
        do_reset();
        issue(3'd3, 5'd0, 1'b0, 32'd0, 32'h40, 32'h100, 1'b0, 4'd0);
        issue(3'd0, 5'd7, 1'b1, 32'h77, 32'h44, 32'd0, 1'b0, 4'd1);
        b.wb_valid = 2'b01; b.wb_idx = {4'd0, 4'd0};
        b.wb_value = {32'd0, 32'd1};
        step();
        clear_in();
        #1;
        chk("br_cm", 64'(b.cm_valid), 0);
        chk("br_preflush", 64'(b.flush), 0);
        step();
        chk("br_flush", 64'(b.flush), 1);
        chk("br_flush_pc", 64'(b.flush_pc), 32'h100);
        chk("br_bp_valid", 64'(b.bp_valid), 1);
        chk("br_bp_taken", 64'(b.bp_taken), 1);
        chk("br_bp_pc", 64'(b.bp_pc), 32'h40);
        chk("br_ready", 64'(b.issue_ready), 0);
        step();
        chk("br_flush_off", 64'(b.flush), 0);
        chk("br_bp_off", 64'(b.bp_valid), 0);
        chk("br_young_cm", 64'(b.cm_valid), 0);
        chk("br_empty_ready", 64'(b.issue_ready), 1);
        chk("br_issue_idx", 64'(b.issue_idx), 0);

        // JALR commits link value and redirects alone
        do_reset();
        issue(3'd4, 5'd1, 1'b0, 32'h24, 32'h20, 32'd0, 1'b0, 4'd0);
        issue(3'd0, 5'd2, 1'b1, 32'h55, 32'h24, 32'd0, 1'b0, 4'd1);
        b.wb_valid = 2'b01; b.wb_idx = {4'd0, 4'd0};
        b.wb_value = {32'd0, 32'h80};
        step();
        clear_in();
        #1;
        chk("jalr_cm_valid", 64'(b.cm_valid), 2'b01);
        chk("jalr_cm_value", 64'(b.cm_value[31:0]), 32'h24);
        chk("jalr_cm_rd", 64'(b.cm_rd[4:0]), 1);
        step();
        chk("jalr_flush", 64'(b.flush), 1);
        chk("jalr_flush_pc", 64'(b.flush_pc), 32'h80);
        chk("jalr_bp_valid", 64'(b.bp_valid), 0);
        step();
        chk("jalr_after_cm", 64'(b.cm_valid), 0);

        // both ports to idx 3: port 0 wins
        do_reset();
        for (int i = 0; i < 4; i++)
            issue(3'd0, 5'(i + 1), 1'b0, 32'd0, 32'd0, 32'd0,
                  1'b0, 4'(i));
        b.wb_valid = 2'b11; b.wb_idx = {4'd3, 4'd3};
        b.wb_value = {32'hBB, 32'hAA};
        b.q_idx = {4'd2, 4'd3};
        #1;
        chk("byp_q_ready", 64'(b.q_ready), 2'b01);
        chk("byp_q_value0", 64'(b.q_value[31:0]), 32'hAA);
        chk("byp_q_value1", 64'(b.q_value[63:32]), 0);
        step();
        b.wb_valid = 2'b01; b.wb_idx = {4'd0, 4'd9};
        b.wb_value = {32'd0, 32'h99};
        b.q_idx = {4'd9, 4'd3};
        #1;
        chk("st_q_ready", 64'(b.q_ready), 2'b01);
        chk("st_q_value0", 64'(b.q_value[31:0]), 32'hAA);
        step();
        clear_in();
        b.q_idx = {4'd9, 4'd3};
        #1;
        chk("idle_wb_q", 64'(b.q_ready), 2'b01);

        // wrap with rdy_in stall
        do_reset();
        for (int i = 0; i < 14; i++)
            issue(3'd0, 5'd1, 1'b1, 32'(i), 32'd0, 32'd0,
                  1'b0, 4'(i));
        step();
        step();
        chk("wrap_head", 64'(b.head_idx), 14);
        chk("wrap_cm_idle", 64'(b.cm_valid), 0);
        for (int i = 0; i < 4; i++)
            issue(3'd0, 5'(i + 3), 1'b0, 32'd0, 32'd0, 32'd0,
                  1'b0, 4'(14 + i));
        b.wb_valid = 2'b11; b.wb_idx = {4'd15, 4'd14};
        b.wb_value = {32'hF, 32'hE};
        step();
        rdy = 1'b0;
        b.wb_idx = {4'd1, 4'd0};
        b.wb_value = {32'h11, 32'h10};
        #1;
        chk("stall_cm", 64'(b.cm_valid), 0);
        chk("stall_ready", 64'(b.issue_ready), 0);
        step();
        step();
        rdy = 1'b1;
        clear_in();
        #1;
        chk("wrap_cm_valid0", 64'(b.cm_valid), 2'b11);
        chk("wrap_cm_idx0", 64'(b.cm_idx), {4'd15, 4'd14});
        chk("wrap_cm_value0", b.cm_value, {32'hF, 32'hE});
        step();
        chk("wrap_stall_wb", 64'(b.cm_valid), 0);
        b.wb_valid = 2'b11; b.wb_idx = {4'd1, 4'd0};
        b.wb_value = {32'h11, 32'h10};
        step();
        clear_in();
        #1;
        chk("wrap_cm_valid1", 64'(b.cm_valid), 2'b11);
        chk("wrap_cm_idx1", 64'(b.cm_idx), {4'd1, 4'd0});
        chk("wrap_cm_value1", b.cm_value, {32'h11, 32'h10});
        step();
        chk("wrap_empty", 64'(b.cm_valid), 0);
        chk("wrap_head_end", 64'(b.head_idx), 2);

        // EXIT halts further commits
        do_reset();
        issue(3'd5, 5'd0, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        issue(3'd0, 5'd4, 1'b1, 32'h33, 32'd0, 32'd0, 1'b0, 4'd1);
        chk("exit_halted", 64'(b.halted), 1);
        chk("exit_no_cm", 64'(b.cm_valid), 0);
        step();
        chk("exit_sticky", 64'(b.halted), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_halted", 64'(b.halted), 0);
        chk("async_rst_cm", 64'(b.cm_valid), 0);
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rob_dual_commit.md
Name: rob_dual_commit

Overview:
- Parametrised successor to the single-commit reorder buffer.
- Circular in-order buffer of DEPTH entries, using a count-based full test so all DEPTH slots are usable.
- Accepts one issue, WB_PORTS writebacks and up to two in-order commits per cycle.
- Resolves branch/JALR at commit: flush pulse, redirect PC and predictor update. Sits between decoder, ALU/LSB writeback, register file, LSB and fetch.

Parameters:
DEPTH, 16, entry count; power of two, >=4
IDX_W, $clog2(DEPTH), entry index width
XLEN, 32, data width
WB_PORTS, 2, writeback ports (>=1)

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, asynchronous, active-low (0 = reset)
rdy_in  in  1  global enable; 0 freezes all state
issue_valid  in  1  decoder presents an entry
issue_type  in  3  0 TOREG, 1 LOAD, 2 STORE, 3 BRANCH, 4 JALR, 5 EXIT
issue_rd  in  5  destination register
issue_done  in  1  entry already complete at issue
issue_value  in  XLEN  initial value (JALR: pc+4)
issue_pc  in  XLEN  instruction PC
issue_target  in  XLEN  branch taken-target
issue_pred_taken  in  1  prediction made at fetch
issue_ready  out  1  (count<DEPTH) && !flush
issue_idx  out  IDX_W  tail index assigned to the presented entry
wb_valid  in  WB_PORTS  per-port result valid
wb_idx  in  WB_PORTS*IDX_W  packed entry indices
wb_value  in  WB_PORTS*XLEN  packed results
q_idx  in  2*IDX_W  two operand lookups
q_ready  out  2  entry complete or written back this cycle
q_value  out  2*XLEN  entry value, else bypassed wb value, else 0
cm_valid  out  2  commit slot 0/1 writes RF this cycle (TOREG/LOAD/JALR)
cm_rd  out  10  packed rd per slot
cm_idx  out  2*IDX_W  packed entry index per slot
cm_value  out  2*XLEN  packed value per slot
head_idx  out  IDX_W  head index
head_is_mem  out  1  non-empty and head type LOAD/STORE
flush  out  1  registered one-cycle redirect pulse
flush_pc  out  XLEN  redirect target
bp_valid, bp_taken  out  1,1  registered predictor update
bp_pc  out  XLEN  PC of resolved branch
halted  out  1  sticky; EXIT committed

Behaviour:
- Reset (async, rst_in=0): head=tail=count=0; all busy/done cleared; flush, flush_pc, bp_*, halted = 0.
- Combinational outputs are 0 whenever rdy_in=0.
- Issue: on edge with rdy_in && issue_valid && issue_ready, write entry at tail; tail+1 mod DEPTH.
- Writeback:
  - Port p with wb_valid[p] to a busy entry sets done and stores the value.
  - JALR: the value goes to the target field; value keeps pc+4.
  - BRANCH: value bit0 = actual taken.
  - Writebacks to non-busy entries are ignored.
  - Two ports to the same index: lowest port wins (q bypass uses the same priority).
- Commit slot 0: head busy && done.
- Commit slot 1:
  - Requires slot 0 committing, head+1 busy && done, and neither entry BRANCH/JALR/EXIT.
  - A flush never coincides with a slot-1 commit.
- Combinational commit view: cm_* reflect the committing slots in the current cycle.
- Count update: count <= count + issued - committed, all in the same edge. Issue when full is ignored; issue into a slot freed the same cycle is not permitted (issue_ready uses pre-edge count).
- Branch commit:
  - bp_valid=1, bp_pc=pc, bp_taken=actual on the next cycle.
  - Mispredict (actual != pred) -> flush=1, flush_pc = actual ? target : pc+4.
- JALR commit: always flush, flush_pc = target.
- On a flushing commit edge, the buffer empties: count=0, head=tail=0, all busy cleared; issue and writebacks in that edge are discarded.
- During the flush cycle, issue_ready=0 and writebacks are ignored.
- flush and bp_valid deassert on the next rdy_in edge.
- EXIT commit sets halted; it stays set until reset, and no further commits occur.
- Wrap-around: head, tail and q indices all wrap mod DEPTH.
- Reset asserted mid-operation: the buffer empties immediately, with no partial commit.

Test Plan:
- Reset, then issue 16 TOREG with issue_done=0 -> issue_ready low after the 16th; issue_idx sequence 0..15; a 17th issue is ignored.
- Writeback idx0=5, idx1=6 simultaneously -> next cycle cm_valid=2'b11, cm_idx={1,0}, cm_value={6,5}; count drops by 2.
- BRANCH pred_taken=0, wb value 1, target 0x100 -> flush=1, flush_pc=0x100, bp_taken=1, count=0 the next cycle; younger entries never commit.
- JALR issue_value=0x24, wb 0x80 -> cm_value slot0=0x24, flush_pc=0x80; the following entry is not co-committed.
- Port0 and port1 both write idx 3 (0xAA / 0xBB) -> stored 0xAA; q_idx=3 in that cycle returns q_ready=1, q_value=0xAA.
- Fill and drain across wrap (head at 14) with rdy_in toggled low mid-stream -> no state change while rdy_in=0; commit order is 14,15,0,1.
